display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_pkg.sv | 34 +++
 rtl/display_scan_hexa7seg.sv | 15 +
 rtl/display_scan.sv | 106 ++++++++++
 tb/tb_display_scan.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// display_scan_pkg
// Shared constants for the multiplexed seven-segment display scanner.
// Holds the active-low segment codes (bit order g..a, bit 6 = g) used by
// the hex decoder and the blanking mux, so no module carries its own
// segment literals.
package display_scan_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // All segments off (active-low).
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low hex glyphs, indexed by nibble value.
  localparam seg_t [15:0] SEG_HEX = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/display_scan_hexa7seg.sv
// hexa7seg
// Purely combinational hex-to-seven-segment decoder, active-low outputs.
// Ports:
//   hex  in  4  nibble to display
//   seg  out 7  segment pattern (bit 6 = g ... bit 0 = a), active-low
module hexa7seg
  import display_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/display_scan.sv
// display_scan
// Time-multiplexes a 32-bit value onto up to eight seven-segment digits.
// Each digit is enabled for DIVIDER clock cycles in turn; the segment
// pattern is decoded from the matching nibble of the value register, with
// optional leading-zero blanking and a per-digit decimal point.
// Ports:
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   wr_en      in   1   load wr_data into the value register
//   wr_data    in   32  new display value, nibble k shown on digit k
//   dp_mask    in   8   decimal point request per digit, active-high
//   blank_lz   in   1   suppress leading zeros
//   seg        out  7   segments of the enabled digit, active-low
//   dp         out  1   decimal point of the enabled digit, active-low
//   an         out  8   digit enables, active-low, one-cold
//   digit_idx  out  3   index of the enabled digit
module display_scan
  import display_scan_pkg::*;
#(
  parameter int DIVIDER = 50000,
  parameter int DIGITS  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic [2:0]  digit_idx
);

  localparam int PW = $clog2(DIVIDER);

  logic [31:0]   value_q;
  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [7:0]    an_q;
  logic          tc;
  logic [2:0]    idx_next;
  nibble_t       cur_nibble;
  seg_t          hex_seg;
  logic          upper_zero;

  assign tc = (presc_q == PW'(DIVIDER - 1));

  // Index of the digit that becomes active when the current slot ends.
  always_comb begin
    idx_next = idx_q + 3'd1;
    if (idx_q == 3'(DIGITS - 1)) begin
      idx_next = 3'd0;
    end
  end

  // Value register: every write wins, the last of a burst is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= 32'h0;
    end else if (wr_en) begin
      value_q <= wr_data;
    end
  end

  // Prescaler and scan position. The enable vector is registered together
  // with the index so the anodes switch cleanly on one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFE;
    end else if (tc) begin
      presc_q <= '0;
      idx_q   <= idx_next;
      an_q    <= ~(8'd1 << idx_next);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign cur_nibble = value_q[{idx_q, 2'b00} +: 4];

  hexa7seg u_hexa7seg (
    .hex (cur_nibble),
    .seg (hex_seg)
  );

  // A digit is a leading zero when it and every more significant digit
  // are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx_q) && value_q[k*4 +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 always shows, so a zero value still displays "0".
  assign seg       = (blank_lz && idx_q != 3'd0 && upper_zero) ? SEG_BLANK : hex_seg;
  assign dp        = ~dp_mask[idx_q];
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
// Scoreboard bench for display_scan with DIVIDER=4, DIGITS=8. The stimulus
// process queues the hand-computed display state for each cycle it drives;
// a monitor on the falling edge pops and compares the entry for that cycle.
module tb_display_scan;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic [2:0]  digit_idx;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   tests;
  int   fails;

  display_scan #(
    .DIVIDER (4),
    .DIGITS  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .dp_mask   (dp_mask),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx)
  );

  // Starts high so the first falling edge precedes the first rising edge.
  initial clock = 1'b1;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every queued expectation stamped with this cycle.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      tests++;
      if (mon_e.cyc < cyc) begin
        fails++;
        $display("[TB] FAIL %s cyc %0d: expectation not sampled (now cyc %0d)",
                 mon_e.name, mon_e.cyc, cyc);
      end else if (an !== mon_e.an || seg !== mon_e.seg || dp !== mon_e.dp ||
                   digit_idx !== mon_e.idx) begin
        fails++;
        $display("[TB] FAIL %s cyc %0d: got an=%h seg=%h dp=%b idx=%0d, want an=%h seg=%h dp=%b idx=%0d",
                 mon_e.name, mon_e.cyc, an, seg, dp, digit_idx,
                 mon_e.an, mon_e.seg, mon_e.dp, mon_e.idx);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] a,
                              input logic [6:0] s, input logic d, input logic [2:0] i);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.an   = a;
    e.seg  = s;
    e.dp   = d;
    e.idx  = i;
    sb.push_back(e);
  endtask

  // One full 32-cycle scan starting at the first cycle of digit 0. Optionally
  // writes on the very last cycle, which is also the terminal count of digit 7.
  task automatic apply_stimulus(input string name, input logic [7:0][6:0] segs,
                                input logic [7:0] dps, input bit do_wr,
                                input logic [31:0] wdata);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        check_output(name, 8'(~(8'd1 << s)), segs[s], dps[s], 3'(s));
        if (do_wr && s == 7 && c == 3) begin
          wr_en   = 1'b1;
          wr_data = wdata;
        end
        tick();
        wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 32'h0;
    dp_mask  = 8'h00;
    blank_lz = 1'b0;

    // Held in reset, with and without a decimal point on digit 0.
    #1;
    check_output("reset", 8'hFE, 7'h40, 1'b1, 3'd0);
    tick();
    dp_mask = 8'h01;
    check_output("reset_dp", 8'hFE, 7'h40, 1'b0, 3'd0);
    tick();
    dp_mask = 8'h00;
    reset   = 1'b0;

    // Idle scan of zero; the write lands on digit 7's terminal count.
    apply_stimulus("idle", {8{7'h40}}, 8'hFF, 1'b1, 32'h89ABCDEF);
    apply_stimulus("hex", {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                   8'hFF, 1'b1, 32'h0000_00A5);
    blank_lz = 1'b1;
    apply_stimulus("lz_on", {{6{7'h7F}}, 7'h08, 7'h12}, 8'hFF, 1'b0, 32'h0);
    blank_lz = 1'b0;
    apply_stimulus("lz_off", {{6{7'h40}}, 7'h08, 7'h12}, 8'hFF, 1'b1, 32'h0);
    blank_lz = 1'b1;
    dp_mask  = 8'h01;
    apply_stimulus("zero_dp", {{7{7'h7F}}, 7'h40}, 8'hFE, 1'b1, 32'h7);
    blank_lz = 1'b0;
    dp_mask  = 8'h00;
    apply_stimulus("wr_tc", {{7{7'h40}}, 7'h78}, 8'hFF, 1'b0, 32'h0);

    // Mid-slot write: visible the cycle after the loading edge, scan unaffected.
    check_output("mid_wr", 8'hFE, 7'h78, 1'b1, 3'd0);
    tick();
    wr_en   = 1'b1;
    wr_data = 32'h0000_0010;
    check_output("mid_wr", 8'hFE, 7'h78, 1'b1, 3'd0);
    tick();
    wr_en = 1'b0;
    check_output("mid_wr", 8'hFE, 7'h40, 1'b1, 3'd0);
    tick();
    check_output("mid_wr", 8'hFE, 7'h40, 1'b1, 3'd0);
    tick();
    check_output("mid_wr", 8'hFD, 7'h79, 1'b1, 3'd1);
    tick();
    tick();
    tick();
    check_output("mid_wr", 8'hFD, 7'h79, 1'b1, 3'd1);
    tick();
    check_output("mid_wr", 8'hFB, 7'h40, 1'b1, 3'd2);
    tick();
    tick();

    // Reset in the middle of digit 2's slot.
    reset = 1'b1;
    #1;
    check_output("mid_rst", 8'hFE, 7'h40, 1'b1, 3'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_output("rst_slot", 8'hFE, 7'h40, 1'b1, 3'd0);
      tick();
    end
    check_output("rst_slot", 8'hFD, 7'h40, 1'b1, 3'd1);
    tick();
    tick();

    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL %s cyc %0d: expectation never checked", mon_e.name, mon_e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    tests++;
    fails++;
    $display("[TB] FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
